// File: rtl/alarm_tone_gen.sv
// Alarm sounder: square-wave tone gated by an on/off beep cadence, PWM volume, optional beep limit.
// Build option: `define ALARM_WARBLE_EN alternates tone A (odd beeps) and tone B (even beeps).
module alarm_tone_gen #(
   parameter int CLK_PER_MS = 100000,
   parameter int DIV_W      = 20,
   parameter int MS_W       = 12,
   parameter int VOL_W      = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Alarm,
   input  logic [DIV_W-1:0] half_div_a,
   input  logic [DIV_W-1:0] half_div_b,
   input  logic [MS_W-1:0]  on_ms,
   input  logic [MS_W-1:0]  off_ms,
   input  logic [VOL_W-1:0] volume,
   input  logic [7:0]       max_beeps,
   output logic             AUD_PWM,
   output logic             AUD_SD,
   output logic [7:0]       beep_count,
   output logic             busy
);
   localparam int PRE_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_MS - 1);
   localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);
   localparam logic [MS_W-1:0]  MS_ONE  = MS_W'(1);
   localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
   localparam logic [VOL_W-1:0] VOL_ONE = VOL_W'(1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ON   = 2'd1;
   localparam logic [1:0] S_OFF  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state, state_nxt;
   logic [PRE_W-1:0] presc;
   logic [MS_W-1:0]  ms_cnt, ms_target;
   logic [MS_W-1:0]  on_lat, off_lat;
   logic [7:0]       max_lat;
   logic [DIV_W-1:0] half_a_lat, half_sel, half_act, div_cnt;
   logic [VOL_W-1:0] carrier;
   logic             sq, tick, phase_end, on_entry, state_chg, active_nxt;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

`ifdef ALARM_WARBLE_EN
   logic [DIV_W-1:0] half_b_lat;
   always_ff @(posedge clk) begin
      if (state == S_IDLE && Alarm) half_b_lat <= half_div_b;
   end
   // beep_count already holds the completed beeps, so an odd count means an even-numbered beep
   always_comb begin
      half_sel = half_a_lat;
      if (state == S_IDLE)    half_sel = half_div_a;
      else if (beep_count[0]) half_sel = half_b_lat;
   end
`else
   logic unused_half_b;
   assign unused_half_b = ^half_div_b;
   always_comb begin
      half_sel = (state == S_IDLE) ? half_div_a : half_a_lat;
   end
`endif

   always_comb begin
      tick       = (presc == PRE_MAX);
      ms_target  = (state == S_ON) ? on_lat : off_lat;
      phase_end  = (ms_target == '0) || (tick && (ms_cnt + MS_ONE == ms_target));
      state_nxt  = state;
      if (!Alarm) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  state_nxt = S_ON;
            S_ON:    if (phase_end) state_nxt = S_OFF;
            S_OFF:   if (phase_end)
                        state_nxt = (max_lat != 8'd0 && beep_count == max_lat) ? S_DONE : S_ON;
            default: state_nxt = S_DONE;
         endcase
      end
      state_chg  = (state_nxt != state);
      on_entry   = (state_nxt == S_ON) && (state != S_ON);
      active_nxt = (state_nxt == S_ON) || (state_nxt == S_OFF);
   end

   // Cadence parameters are captured once per alarm; only volume tracks live
   always_ff @(posedge clk) begin
      if (state == S_IDLE && Alarm) begin
         on_lat     <= on_ms;
         off_lat    <= off_ms;
         max_lat    <= max_beeps;
         half_a_lat <= half_div_a;
      end
      if (on_entry) half_act <= half_sel;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         presc      <= '0;
         ms_cnt     <= '0;
         div_cnt    <= '0;
         sq         <= 1'b0;
         carrier    <= '0;
         beep_count <= 8'd0;
         AUD_PWM    <= 1'b0;
         AUD_SD     <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state   <= state_nxt;
         carrier <= carrier + VOL_ONE;

         if (state_chg || tick) presc <= '0;
         else                   presc <= presc + PRE_ONE;

         if (state_chg) ms_cnt <= '0;
         else if (tick) ms_cnt <= ms_cnt + MS_ONE;

         if (state_nxt == S_IDLE)                      beep_count <= 8'd0;
         else if (state == S_ON && state_nxt == S_OFF) beep_count <= sat_inc(beep_count);

         // Tone divider restarts at each beep so every beep begins on a low half-cycle
         if (on_entry) begin
            div_cnt <= '0;
            sq      <= 1'b0;
         end else if (state == S_ON) begin
            if (half_act == '0) begin
               div_cnt <= '0;
               sq      <= 1'b0;
            end else if (div_cnt + DIV_ONE == half_act) begin
               div_cnt <= '0;
               sq      <= ~sq;
            end else begin
               div_cnt <= div_cnt + DIV_ONE;
            end
         end

         AUD_PWM <= Alarm & sq & (carrier < volume) & (state == S_ON);
         AUD_SD  <= active_nxt;
         busy    <= active_nxt;
      end
   end
endmodule
